// File: rtl/vtg_pkg.sv
// rtl/vtg_pkg.sv - shared phase type, default 640x480 timing and colour-bar table for video_timing_gen
package vtg_pkg;

    typedef enum logic [1:0] {
        ACTIVE = 2'd0,
        FP     = 2'd1,
        SYNC   = 2'd2,
        BP     = 2'd3
    } vtg_phase_t;

    localparam int VTG_CW = 12;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    // White, yellow, cyan, green, magenta, red, blue, black
    localparam logic [23:0] VTG_BAR_RGB [0:7] = '{
        24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
        24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
    };

endpackage

// File: rtl/vtg_axis.sv
// rtl/vtg_axis.sv - one raster axis: ACTIVE/FP/SYNC/BP phase FSM, phase down-counter, active position counter
module vtg_axis
    import vtg_pkg::*;
(
    input  logic              i_clk,
    input  logic              i_rst_n,
    input  logic              i_adv,
    input  logic [VTG_CW-1:0] i_len_active,
    input  logic [VTG_CW-1:0] i_len_fp,
    input  logic [VTG_CW-1:0] i_len_sync,
    input  logic [VTG_CW-1:0] i_len_bp,
    output vtg_phase_t        o_state,
    output logic [VTG_CW-1:0] o_pos,
    output logic              o_wrap
);

    vtg_phase_t        r_state;
    vtg_phase_t        w_state_nxt;
    logic [VTG_CW-1:0] r_cnt;
    logic [VTG_CW-1:0] w_cnt_nxt;
    logic [VTG_CW-1:0] r_pos;
    logic [VTG_CW-1:0] w_pos_nxt;
    logic              w_last;

    assign w_last = (r_cnt == '0);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state <= ACTIVE;
            r_cnt   <= i_len_active - 12'd1;
            r_pos   <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_pos   <= w_pos_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_pos_nxt   = r_pos;
        if (i_adv) begin
            if (w_last) begin
                // Position only counts inside ACTIVE, so every phase exit clears it
                w_pos_nxt = '0;
                case (r_state)
                    ACTIVE: begin w_state_nxt = FP;     w_cnt_nxt = i_len_fp     - 12'd1; end
                    FP:     begin w_state_nxt = SYNC;   w_cnt_nxt = i_len_sync   - 12'd1; end
                    SYNC:   begin w_state_nxt = BP;     w_cnt_nxt = i_len_bp     - 12'd1; end
                    default: begin w_state_nxt = ACTIVE; w_cnt_nxt = i_len_active - 12'd1; end
                endcase
            end else begin
                w_cnt_nxt = r_cnt - 12'd1;
                if (r_state == ACTIVE) begin
                    w_pos_nxt = r_pos + 12'd1;
                end
            end
        end
    end

    assign o_state = r_state;
    assign o_pos   = r_pos;
    assign o_wrap  = i_adv && (r_state == BP) && w_last;

endmodule

// File: rtl/video_timing_gen.sv
// rtl/video_timing_gen.sv - raster timing for hdmi.hve; colour bars on o_rgb when VTG_TEST_PATTERN_EN is defined
module video_timing_gen
    import vtg_pkg::*;
#(
    parameter int H_ACTIVE   = DEF_H_ACTIVE,
    parameter int H_FP       = DEF_H_FP,
    parameter int H_SYNC     = DEF_H_SYNC,
    parameter int H_BP       = DEF_H_BP,
    parameter int V_ACTIVE   = DEF_V_ACTIVE,
    parameter int V_FP       = DEF_V_FP,
    parameter int V_SYNC     = DEF_V_SYNC,
    parameter int V_BP       = DEF_V_BP,
    parameter int H_SYNC_POL = 0,
    parameter int V_SYNC_POL = 0
) (
    input  logic        i_hdmi_clk,
    input  logic        i_reset_n,
    output logic [2:0]  o_hve,
    output logic [11:0] o_x,
    output logic [11:0] o_y,
    output logic        o_line_start,
    output logic        o_frame_start,
    output logic [23:0] o_rgb
);

    localparam logic H_POL = (H_SYNC_POL != 0);
    localparam logic V_POL = (V_SYNC_POL != 0);

    vtg_phase_t  w_h_state;
    vtg_phase_t  w_v_state;
    logic [11:0] w_h_pos;
    logic [11:0] w_v_pos;
    logic        w_h_wrap;
    logic        w_v_wrap_unused;
    logic        w_de;

    logic [2:0]  r_hve;
    logic [11:0] r_x;
    logic [11:0] r_y;
    logic        r_line_start;
    logic        r_frame_start;

    vtg_axis u_h_axis (
        .i_clk        (i_hdmi_clk),
        .i_rst_n      (i_reset_n),
        .i_adv        (1'b1),
        .i_len_active (12'(H_ACTIVE)),
        .i_len_fp     (12'(H_FP)),
        .i_len_sync   (12'(H_SYNC)),
        .i_len_bp     (12'(H_BP)),
        .o_state      (w_h_state),
        .o_pos        (w_h_pos),
        .o_wrap       (w_h_wrap)
    );

    // Vertical axis steps once per line, so vsync edges land on line boundaries
    vtg_axis u_v_axis (
        .i_clk        (i_hdmi_clk),
        .i_rst_n      (i_reset_n),
        .i_adv        (w_h_wrap),
        .i_len_active (12'(V_ACTIVE)),
        .i_len_fp     (12'(V_FP)),
        .i_len_sync   (12'(V_SYNC)),
        .i_len_bp     (12'(V_BP)),
        .o_state      (w_v_state),
        .o_pos        (w_v_pos),
        .o_wrap       (w_v_wrap_unused)
    );

    assign w_de = (w_h_state == ACTIVE) && (w_v_state == ACTIVE);

    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_hve         <= {1'b0, ~V_POL, ~H_POL};
            r_x           <= '0;
            r_y           <= '0;
            r_line_start  <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_hve         <= {w_de,
                              (w_v_state == SYNC) ? V_POL : ~V_POL,
                              (w_h_state == SYNC) ? H_POL : ~H_POL};
            r_x           <= w_de ? w_h_pos : 12'd0;
            r_y           <= w_v_pos;
            r_line_start  <= w_de && (w_h_pos == 12'd0);
            r_frame_start <= w_de && (w_h_pos == 12'd0) && (w_v_pos == 12'd0);
        end
    end

    assign o_hve         = r_hve;
    assign o_x           = r_x;
    assign o_y           = r_y;
    assign o_line_start  = r_line_start;
    assign o_frame_start = r_frame_start;

`ifdef VTG_TEST_PATTERN_EN
    localparam logic [11:0] BAR_W    = 12'(H_ACTIVE / 8);
    localparam logic [11:0] H_LAST_X = 12'(H_ACTIVE - 1);

    logic [11:0] r_bar_px;
    logic [2:0]  r_bar_idx;
    logic [23:0] r_rgb;

    // Bar index tracks the current h position, so it is registered alongside o_hve
    always_ff @(posedge i_hdmi_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            r_bar_px  <= '0;
            r_bar_idx <= '0;
            r_rgb     <= '0;
        end else begin
            if (w_h_state == ACTIVE) begin
                if (w_h_pos == H_LAST_X) begin
                    r_bar_px  <= '0;
                    r_bar_idx <= '0;
                end else if (r_bar_px == BAR_W - 12'd1) begin
                    r_bar_px  <= '0;
                    r_bar_idx <= r_bar_idx + 3'd1;
                end else begin
                    r_bar_px  <= r_bar_px + 12'd1;
                end
            end
            r_rgb <= w_de ? VTG_BAR_RGB[r_bar_idx] : 24'h0;
        end
    end

    assign o_rgb = r_rgb;
`else
    assign o_rgb = 24'h0;
`endif

endmodule
